// File: rtl/pkt_meta_rr_arbiter.sv
// pkt_meta_rr_arbiter
//   Merges NUM_CH packet channels into one output ahead of the shared
//   parser/matcher datapath. Each channel carries a 512-bit flit stream
//   and a metadata stream (one metadata per packet). Channels are served
//   round-robin at packet granularity: the winner's metadata is forwarded
//   first, then every flit of its packet through eop. There is no data
//   buffering; the output buses are muxes of the granted channel.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   in_pkt_*                  per-channel flit streams (flattened buses)
//   in_pkt_ready              per-channel flit accept (granted channel only)
//   in_meta_data/valid/ready  per-channel metadata stream
//   out_pkt_*                 merged flit stream + source channel
//   out_meta_*                merged metadata stream + source channel
//   stat_pkt_cnt              packets forwarded (eop handshakes), wraps
//   stat_err_cnt              sop seen on a non-first flit, wraps

typedef struct packed {
  logic [15:0] flow_id;
  logic [15:0] pkt_len;
  logic [7:0]  ingress_port;
  logic [7:0]  flags;
  logic [15:0] hash;
} metadata_t;

module pkt_meta_rr_arbiter #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_CH*512-1:0]                in_pkt_data,
  input  logic [NUM_CH-1:0]                    in_pkt_valid,
  input  logic [NUM_CH-1:0]                    in_pkt_sop,
  input  logic [NUM_CH-1:0]                    in_pkt_eop,
  input  logic [NUM_CH*6-1:0]                  in_pkt_empty,
  output logic [NUM_CH-1:0]                    in_pkt_ready,
  input  logic [NUM_CH*$bits(metadata_t)-1:0]  in_meta_data,
  input  logic [NUM_CH-1:0]                    in_meta_valid,
  output logic [NUM_CH-1:0]                    in_meta_ready,
  output logic [511:0]                         out_pkt_data,
  output logic                                 out_pkt_valid,
  output logic                                 out_pkt_sop,
  output logic                                 out_pkt_eop,
  output logic [5:0]                           out_pkt_empty,
  output logic [CH_W-1:0]                      out_pkt_channel,
  input  logic                                 out_pkt_ready,
  output metadata_t                            out_meta_data,
  output logic                                 out_meta_valid,
  output logic [CH_W-1:0]                      out_meta_channel,
  input  logic                                 out_meta_ready,
  output logic [31:0]                          stat_pkt_cnt,
  output logic [31:0]                          stat_err_cnt
);

  localparam int DATA_W  = 512;
  localparam int EMPTY_W = 6;
  localparam int META_W  = $bits(metadata_t);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    META = 2'd1,
    PKT  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CH_W-1:0]   grant;
  logic [CH_W-1:0]   rr_ptr;
  // Set once the metadata is accepted; cleared by the first flit handshake.
  logic              first_flit;

  logic [DATA_W-1:0]  ch_data  [NUM_CH];
  logic [EMPTY_W-1:0] ch_empty [NUM_CH];
  metadata_t          ch_meta  [NUM_CH];
  logic [NUM_CH-1:0]  eligible;

  logic              arb_found;
  logic [CH_W-1:0]   arb_pick;

  logic              gnt_meta_vld;
  logic              gnt_pkt_vld;
  logic              gnt_sop;
  logic              gnt_eop;
  logic              meta_hs;
  logic              flit_hs;
  logic              pkt_done;
  logic              sop_err;

  function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] ch);
    if (ch == CH_W'(NUM_CH - 1)) begin
      return '0;
    end
    return ch + 1'b1;
  endfunction

  for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
    assign ch_data[i]  = in_pkt_data[i*DATA_W +: DATA_W];
    assign ch_empty[i] = in_pkt_empty[i*EMPTY_W +: EMPTY_W];
    assign ch_meta[i]  = metadata_t'(in_meta_data[i*META_W +: META_W]);
  end

  // A channel may only win with a packet head and its metadata both present.
  assign eligible = in_meta_valid & in_pkt_valid & in_pkt_sop;

  // Round-robin search starting at rr_ptr; modulo keeps non-power-of-two
  // channel counts in range.
  always_comb begin
    int idx;
    arb_found = 1'b0;
    arb_pick  = '0;
    idx       = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_CH;
      if (!arb_found && eligible[CH_W'(idx)]) begin
        arb_found = 1'b1;
        arb_pick  = CH_W'(idx);
      end
    end
  end

  assign gnt_meta_vld = in_meta_valid[grant];
  assign gnt_pkt_vld  = in_pkt_valid[grant];
  assign gnt_sop      = in_pkt_sop[grant];
  assign gnt_eop      = in_pkt_eop[grant];

  assign meta_hs  = (state == META) && gnt_meta_vld && out_meta_ready;
  assign flit_hs  = (state == PKT) && gnt_pkt_vld && out_pkt_ready;
  assign pkt_done = flit_hs && gnt_eop;
  // The flit is still forwarded; only the count records the framing error.
  assign sop_err  = flit_hs && gnt_sop && !first_flit;

  assign out_meta_channel = grant;
  assign out_pkt_channel  = grant;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    out_meta_valid = 1'b0;
    out_meta_data  = '0;
    in_meta_ready  = '0;
    out_pkt_valid  = 1'b0;
    out_pkt_data   = '0;
    out_pkt_sop    = 1'b0;
    out_pkt_eop    = 1'b0;
    out_pkt_empty  = '0;
    in_pkt_ready   = '0;
    case (state)
      IDLE: begin
        if (arb_found) begin
          state_nxt = META;
        end
      end
      META: begin
        out_meta_valid       = gnt_meta_vld;
        out_meta_data        = ch_meta[grant];
        in_meta_ready[grant] = out_meta_ready;
        if (gnt_meta_vld && out_meta_ready) begin
          state_nxt = PKT;
        end
      end
      PKT: begin
        out_pkt_valid       = gnt_pkt_vld;
        out_pkt_data        = ch_data[grant];
        out_pkt_sop         = gnt_sop;
        out_pkt_eop         = gnt_eop;
        out_pkt_empty       = ch_empty[grant];
        in_pkt_ready[grant] = out_pkt_ready;
        if (gnt_pkt_vld && out_pkt_ready && gnt_eop) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant        <= '0;
      rr_ptr       <= '0;
      first_flit   <= 1'b0;
      stat_pkt_cnt <= '0;
      stat_err_cnt <= '0;
    end else begin
      if (state == IDLE && arb_found) begin
        grant <= arb_pick;
      end
      if (meta_hs) begin
        first_flit <= 1'b1;
      end else if (flit_hs) begin
        first_flit <= 1'b0;
      end
      if (pkt_done) begin
        stat_pkt_cnt <= stat_pkt_cnt + 32'd1;
        rr_ptr       <= next_ch(grant);
      end
      if (sop_err) begin
        stat_err_cnt <= stat_err_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_pkt_meta_rr_arbiter.sv
module tb_pkt_meta_rr_arbiter;
  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;
  localparam int DW     = 512;
  localparam int MW     = 64;
  localparam int MAXP   = 32;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [NUM_CH*DW-1:0]   in_pkt_data = '0;
  logic [NUM_CH-1:0]      in_pkt_valid = '0;
  logic [NUM_CH-1:0]      in_pkt_sop = '0;
  logic [NUM_CH-1:0]      in_pkt_eop = '0;
  logic [NUM_CH*6-1:0]    in_pkt_empty = '0;
  logic [NUM_CH-1:0]      in_pkt_ready;
  logic [NUM_CH*MW-1:0]   in_meta_data = '0;
  logic [NUM_CH-1:0]      in_meta_valid = '0;
  logic [NUM_CH-1:0]      in_meta_ready;
  logic [DW-1:0]          out_pkt_data;
  logic                   out_pkt_valid;
  logic                   out_pkt_sop;
  logic                   out_pkt_eop;
  logic [5:0]             out_pkt_empty;
  logic [CH_W-1:0]        out_pkt_channel;
  logic                   out_pkt_ready = 1'b0;
  logic [MW-1:0]          out_meta_data;
  logic                   out_meta_valid;
  logic [CH_W-1:0]        out_meta_channel;
  logic                   out_meta_ready = 1'b0;
  logic [31:0]            stat_pkt_cnt;
  logic [31:0]            stat_err_cnt;

  always #5 clk = ~clk;

  pkt_meta_rr_arbiter #(.NUM_CH(NUM_CH), .CH_W(CH_W)) dut (
    .clk(clk), .rst(rst),
    .in_pkt_data(in_pkt_data), .in_pkt_valid(in_pkt_valid),
    .in_pkt_sop(in_pkt_sop), .in_pkt_eop(in_pkt_eop),
    .in_pkt_empty(in_pkt_empty), .in_pkt_ready(in_pkt_ready),
    .in_meta_data(in_meta_data), .in_meta_valid(in_meta_valid),
    .in_meta_ready(in_meta_ready),
    .out_pkt_data(out_pkt_data), .out_pkt_valid(out_pkt_valid),
    .out_pkt_sop(out_pkt_sop), .out_pkt_eop(out_pkt_eop),
    .out_pkt_empty(out_pkt_empty), .out_pkt_channel(out_pkt_channel),
    .out_pkt_ready(out_pkt_ready),
    .out_meta_data(out_meta_data), .out_meta_valid(out_meta_valid),
    .out_meta_channel(out_meta_channel), .out_meta_ready(out_meta_ready),
    .stat_pkt_cnt(stat_pkt_cnt), .stat_err_cnt(stat_err_cnt)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Packet tables per channel
  int          n_pkts  [NUM_CH];
  int          p_len   [NUM_CH][MAXP];
  int          p_err   [NUM_CH][MAXP];   // flit index carrying a stray sop, 0 = none
  logic [5:0]  p_empty [NUM_CH][MAXP];
  logic [63:0] p_meta  [NUM_CH][MAXP];
  logic [31:0] salt;

  // Source state
  int s_p [NUM_CH];
  int s_f [NUM_CH];
  bit s_md[NUM_CH];
  bit hs_meta[NUM_CH];
  bit hs_pkt [NUM_CH];
  int vld_pct = 100;
  int mrdy_pct = 100;
  int prdy_pct = 100;
  bit prdy_toggle = 1'b0;
  bit tog = 1'b0;

  // Reference model state
  bit          m_free = 1'b1;
  bit          m_pend = 1'b0;
  int          m_cur = 0;
  int          m_rr = 0;
  int          m_f = 0;
  int          m_p [NUM_CH];
  logic [31:0] m_pkt = '0;
  logic [31:0] m_err = '0;
  int          m_log[$];
  int          d_log[$];
  int          flit_hs_cnt = 0;

  function automatic logic [DW-1:0] flit_data(input int ch, input int p, input int f);
    logic [DW-1:0] d;
    d = '0;
    for (int w = 0; w < DW/32; w++)
      d[w*32 +: 32] = salt ^ 32'(ch << 24) ^ 32'(p << 12) ^ 32'(f << 4) ^ (32'(w) * 32'h9E3779B9);
    return d;
  endfunction

  task automatic add_pkt(input int ch, input int len, input int err,
                         input logic [5:0] emp, input logic [63:0] meta);
    p_len[ch][n_pkts[ch]]   = len;
    p_err[ch][n_pkts[ch]]   = err;
    p_empty[ch][n_pkts[ch]] = emp;
    p_meta[ch][n_pkts[ch]]  = meta;
    n_pkts[ch]++;
  endtask

  task automatic drive();
    logic [NUM_CH*DW-1:0] d;
    logic [NUM_CH*MW-1:0] md;
    logic [NUM_CH*6-1:0]  em;
    logic [NUM_CH-1:0]    mv, pv, sp, ep;
    d = '0; md = '0; em = '0; mv = '0; pv = '0; sp = '0; ep = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (s_p[c] < n_pkts[c]) begin
        int p;
        int f;
        p = s_p[c];
        f = s_f[c];
        mv[c] = !s_md[c] && ($urandom_range(99) < 32'(vld_pct));
        pv[c] = $urandom_range(99) < 32'(vld_pct);
        md[c*MW +: MW] = p_meta[c][p];
        d[c*DW +: DW]  = flit_data(c, p, f);
        sp[c] = (f == 0) || (f == p_err[c][p]);
        ep[c] = (f == p_len[c][p] - 1);
        em[c*6 +: 6] = ep[c] ? p_empty[c][p] : 6'd0;
      end
    end
    in_pkt_data = d; in_meta_data = md; in_pkt_empty = em;
    in_meta_valid = mv; in_pkt_valid = pv; in_pkt_sop = sp; in_pkt_eop = ep;
    out_meta_ready = $urandom_range(99) < 32'(mrdy_pct);
    if (prdy_toggle) begin
      tog = !tog;
      out_pkt_ready = tog;
    end else begin
      out_pkt_ready = $urandom_range(99) < 32'(prdy_pct);
    end
  endtask

  task automatic clear_sources();
    for (int c = 0; c < NUM_CH; c++) begin
      n_pkts[c] = 0; s_p[c] = 0; s_f[c] = 0; s_md[c] = 1'b0;
      hs_meta[c] = 1'b0; hs_pkt[c] = 1'b0;
    end
  endtask

  // One clock: apply last cycle's handshakes to the sources, drive the next
  // inputs after the edge, return just after the compare at the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
    for (int c = 0; c < NUM_CH; c++) begin
      if (hs_meta[c]) s_md[c] = 1'b1;
      if (hs_pkt[c]) begin
        s_f[c]++;
        if (s_f[c] == p_len[c][s_p[c]]) begin
          s_f[c] = 0; s_p[c]++; s_md[c] = 1'b0;
        end
      end
      hs_meta[c] = 1'b0; hs_pkt[c] = 1'b0;
    end
    drive();
    @(negedge clk);
    #1;
  endtask

  function automatic bit all_done();
    bit r;
    r = m_free;
    for (int c = 0; c < NUM_CH; c++) if (m_p[c] != n_pkts[c]) r = 1'b0;
    return r;
  endfunction

  task automatic run_until_idle(input string name, input int max_cyc);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!all_done() && n < max_cyc);
    if (!all_done()) begin
      tests++; fails++;
      $display("FAIL %s: timeout after %0d cycles", name, n);
    end
  endtask

  // Reference model + compare, once per cycle on the falling edge.
  always @(negedge clk) begin
    logic [NUM_CH-1:0] e;
    int p;
    int pick;
    if (rst) begin
      chk("rst_meta_vld", out_meta_valid, 1'b0);
      chk("rst_pkt_vld", out_pkt_valid, 1'b0);
      chk("rst_meta_rdy", in_meta_ready, '0);
      chk("rst_pkt_rdy", in_pkt_ready, '0);
      chk("rst_pkt_data", out_pkt_data, '0);
      chk("rst_meta_data", out_meta_data, '0);
      chk("rst_pkt_cnt", stat_pkt_cnt, '0);
      chk("rst_err_cnt", stat_err_cnt, '0);
      m_free = 1'b1; m_pend = 1'b0; m_rr = 0; m_f = 0; m_pkt = '0; m_err = '0;
      for (int c = 0; c < NUM_CH; c++) begin
        m_p[c] = 0; hs_meta[c] = 1'b0; hs_pkt[c] = 1'b0;
      end
    end else begin
      chk("stat_pkt_cnt", stat_pkt_cnt, m_pkt);
      chk("stat_err_cnt", stat_err_cnt, m_err);
      for (int c = 0; c < NUM_CH; c++) begin
        hs_meta[c] = in_meta_valid[c] && in_meta_ready[c];
        hs_pkt[c]  = in_pkt_valid[c] && in_pkt_ready[c];
      end
      if (m_free) begin
        chk("idle_meta_vld", out_meta_valid, 1'b0);
        chk("idle_pkt_vld", out_pkt_valid, 1'b0);
        chk("idle_meta_rdy", in_meta_ready, '0);
        chk("idle_pkt_rdy", in_pkt_ready, '0);
        pick = -1;
        for (int k = 0; k < NUM_CH; k++) begin
          int idx;
          idx = (m_rr + k) % NUM_CH;
          if (pick < 0 && in_meta_valid[idx] && in_pkt_valid[idx] && in_pkt_sop[idx]) pick = idx;
        end
        if (pick >= 0) begin
          m_free = 1'b0; m_pend = 1'b1; m_cur = pick;
          m_log.push_back(pick);
        end
      end else if (m_pend) begin
        p = m_p[m_cur];
        e = '0;
        if (out_meta_ready) e[m_cur] = 1'b1;
        chk("meta_vld", out_meta_valid, in_meta_valid[m_cur]);
        chk("meta_ch", out_meta_channel, m_cur);
        chk("meta_rdy", in_meta_ready, e);
        chk("meta_pkt_rdy", in_pkt_ready, '0);
        chk("meta_pkt_vld", out_pkt_valid, 1'b0);
        if (in_meta_valid[m_cur]) chk("meta_data", out_meta_data, p_meta[m_cur][p]);
        if (in_meta_valid[m_cur] && out_meta_ready) begin
          m_pend = 1'b0; m_f = 0;
          d_log.push_back(int'(out_meta_channel));
        end
      end else begin
        p = m_p[m_cur];
        e = '0;
        if (out_pkt_ready) e[m_cur] = 1'b1;
        chk("pkt_vld", out_pkt_valid, in_pkt_valid[m_cur]);
        chk("pkt_rdy", in_pkt_ready, e);
        chk("pkt_meta_rdy", in_meta_ready, '0);
        chk("pkt_meta_vld", out_meta_valid, 1'b0);
        if (in_pkt_valid[m_cur]) begin
          chk("pkt_data", out_pkt_data, flit_data(m_cur, p, m_f));
          chk("pkt_sop", out_pkt_sop, (m_f == 0) || (m_f == p_err[m_cur][p]));
          chk("pkt_eop", out_pkt_eop, m_f == p_len[m_cur][p] - 1);
          if (m_f == p_len[m_cur][p] - 1) chk("pkt_empty", out_pkt_empty, p_empty[m_cur][p]);
          chk("pkt_ch", out_pkt_channel, m_cur);
        end
        if (in_pkt_valid[m_cur] && out_pkt_ready) begin
          flit_hs_cnt++;
          if (m_f > 0 && m_f == p_err[m_cur][p]) m_err = m_err + 32'd1;
          m_f++;
          if (m_f == p_len[m_cur][p]) begin
            m_pkt = m_pkt + 32'd1;
            m_p[m_cur]++;
            m_rr = (m_cur + 1) % NUM_CH;
            m_free = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fc0;
    int exp_err;
    salt = $urandom;
    clear_sources();
    for (int c = 0; c < NUM_CH; c++) m_p[c] = 0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("reset_meta_vld", out_meta_valid, 1'b0);
    chk("reset_pkt_cnt", stat_pkt_cnt, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    #1;

    // Fairness: 3 single-flit packets on every channel, all continuously eligible
    m_log.delete(); d_log.delete();
    for (int c = 0; c < NUM_CH; c++)
      for (int k = 0; k < 3; k++) add_pkt(c, 1, 0, 6'(c), {32'(c), 32'(k)});
    run_until_idle("fairness", 200);
    chk("fair_model_n", m_log.size(), 12);
    chk("fair_dut_n", d_log.size(), 12);
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("fair_model_%0d", i), m_log[i], i % 4);
      chk($sformatf("fair_dut_%0d", i), d_log[i], i % 4);
    end

    // Single 3-flit packet on ch2
    add_pkt(2, 3, 0, 6'd5, 64'h0002_0003_AA55_1234);
    step();
    chk("c1_meta_vld", out_meta_valid, 1'b0);
    chk("c1_pkt_cnt", stat_pkt_cnt, 32'd12);
    step();
    chk("c2_meta_vld", out_meta_valid, 1'b1);
    chk("c2_meta_ch", out_meta_channel, 2'd2);
    chk("c2_meta_data", out_meta_data, 64'h0002_0003_AA55_1234);
    step();
    chk("c3_sop", out_pkt_sop, 1'b1);
    chk("c3_eop", out_pkt_eop, 1'b0);
    step();
    chk("c4_sop", out_pkt_sop, 1'b0);
    step();
    chk("c5_eop", out_pkt_eop, 1'b1);
    chk("c5_empty", out_pkt_empty, 6'd5);
    step();
    chk("c6_pkt_cnt", stat_pkt_cnt, 32'd13);
    chk("c6_pkt_vld", out_pkt_valid, 1'b0);

    // Wrap and skip: pointer at 3, only ch1 eligible; afterwards pointer at 2
    add_pkt(1, 1, 0, 6'd1, 64'h1111);
    step();
    step();
    chk("d_meta_ch1", out_meta_channel, 2'd1);
    chk("d_meta_vld1", out_meta_valid, 1'b1);
    add_pkt(1, 1, 0, 6'd1, 64'h1112);
    add_pkt(2, 1, 0, 6'd2, 64'h2222);
    add_pkt(3, 1, 0, 6'd3, 64'h3333);
    step();
    step();
    step();
    chk("d_meta_ch2", out_meta_channel, 2'd2);
    run_until_idle("wrap", 100);

    // Backpressure: metadata held, then toggling flit ready on a 4-flit packet
    add_pkt(0, 4, 0, 6'd9, 64'hBEEF_0000_CAFE_0004);
    mrdy_pct = 0;
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("bp_meta_vld_%0d", i), out_meta_valid, 1'b1);
      chk($sformatf("bp_meta_rdy_%0d", i), in_meta_ready, 4'b0000);
      chk($sformatf("bp_meta_data_%0d", i), out_meta_data, 64'hBEEF_0000_CAFE_0004);
    end
    mrdy_pct = 100;
    prdy_toggle = 1'b1;
    fc0 = flit_hs_cnt;
    run_until_idle("backpressure", 100);
    chk("bp_flits", flit_hs_cnt - fc0, 4);
    prdy_toggle = 1'b0;

    // Protocol error: stray sop on the second of three flits
    add_pkt(3, 3, 1, 6'd2, 64'hE770);
    run_until_idle("proto_err", 100);
    step();
    chk("err_cnt", stat_err_cnt, 32'd1);
    chk("err_pkt_cnt", stat_pkt_cnt, 32'd19);

    // Reset pulsed during flit 2 of 4
    add_pkt(1, 4, 0, 6'd0, 64'h4444);
    step();
    step();
    step();
    step();
    #2 rst = 1'b1;
    #1;
    chk("rm_meta_vld", out_meta_valid, 1'b0);
    chk("rm_pkt_vld", out_pkt_valid, 1'b0);
    chk("rm_pkt_rdy", in_pkt_ready, 4'b0000);
    chk("rm_meta_rdy", in_meta_ready, 4'b0000);
    chk("rm_pkt_cnt", stat_pkt_cnt, 32'd0);
    chk("rm_err_cnt", stat_err_cnt, 32'd0);
    clear_sources();
    drive();
    @(negedge clk);
    #1 rst = 1'b0;
    add_pkt(0, 2, 0, 6'd7, 64'h0000_5EED);
    step();
    step();
    chk("rm_next_ch", out_meta_channel, 2'd0);
    chk("rm_next_vld", out_meta_valid, 1'b1);
    run_until_idle("after_reset", 100);
    step();
    chk("rm_next_cnt", stat_pkt_cnt, 32'd1);

    // Randomized traffic with random valid/ready gaps and occasional stray sop
    exp_err = 0;
    for (int c = 0; c < NUM_CH; c++)
      for (int k = 0; k < 20; k++) begin
        int len;
        int err;
        len = int'($urandom_range(6, 1));
        err = 0;
        if (len >= 2 && $urandom_range(4) == 0) begin
          err = int'($urandom_range(len - 1, 1));
          exp_err++;
        end
        add_pkt(c, len, err, 6'($urandom_range(63)), {$urandom, $urandom});
      end
    vld_pct = 70; mrdy_pct = 70; prdy_pct = 70;
    run_until_idle("random", 20000);
    step();
    chk("rand_pkt_cnt", stat_pkt_cnt, 32'd81);
    chk("rand_err_cnt", stat_err_cnt, 32'(exp_err));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pkt_meta_rr_arbiter.md
Name: pkt_meta_rr_arbiter

Overview:
- Merges NUM_CH input channels into one output channel.
- Each input channel carries a 512-bit packet stream plus a metadata_t stream, one metadata per packet.
- Arbitration is round-robin at packet granularity: the metadata is forwarded first, then every flit of that packet through eop, before another channel is served.
- Sits ahead of the shared parser/matcher datapath.
- Exports packet and error counters for the debug/status path.

Parameters:
- NUM_CH, 4, number of input channels (2..8).
- CH_W, $clog2(NUM_CH), channel index width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_pkt_data  in  NUM_CH*512  flattened per-channel flit data; channel i at [i*512 +: 512]
- in_pkt_valid / in_pkt_sop / in_pkt_eop  in  NUM_CH each  per-channel flit qualifiers
- in_pkt_empty  in  NUM_CH*6  per-channel empty bytes on eop
- in_pkt_ready  out  NUM_CH  per-channel flit accept
- in_meta_data  in  NUM_CH*$bits(metadata_t)  per-channel metadata
- in_meta_valid  in  NUM_CH  per-channel metadata valid
- in_meta_ready  out  NUM_CH  per-channel metadata accept
- out_pkt_data / out_pkt_valid / out_pkt_sop / out_pkt_eop / out_pkt_empty  out  512/1/1/1/6  merged flit stream
- out_pkt_channel  out  CH_W  source channel of the current flit
- out_pkt_ready  in  1  downstream flit accept
- out_meta_data  out  metadata_t  merged metadata
- out_meta_valid  out  1  merged metadata valid
- out_meta_channel  out  CH_W  source channel of the metadata
- out_meta_ready  in  1  downstream metadata accept
- stat_pkt_cnt  out  32  packets forwarded (eop handshakes)
- stat_err_cnt  out  32  protocol errors detected

Behaviour:
- Reset is asynchronous and active-high on rst; the block has one clock, clk.
- Reset values:
  - state = IDLE, rr_ptr = 0, grant = 0.
  - All out_*_valid = 0, all in_*_ready = 0.
  - out_* data fields = 0.
  - stat_pkt_cnt = 0, stat_err_cnt = 0.
- Handshake: a transfer occurs when valid & ready are both high in the same cycle. Ready is never a function of its own interface's valid.
- Data path: out_pkt_* and out_meta_* are combinational muxes of the granted channel, selected by the registered grant. There is no data buffering in the block.
- Ungranted channels always see in_pkt_ready = 0 and in_meta_ready = 0.
- Channel i is eligible when in_meta_valid[i] & in_pkt_valid[i] & in_pkt_sop[i].
- State IDLE:
  - All outputs invalid.
  - Pick the first eligible channel scanning rr_ptr, rr_ptr+1, … modulo NUM_CH.
  - If one is found: grant <= that channel; next state META.
  - If none is eligible: stay in IDLE.
- State META:
  - out_meta_valid = 1, out_meta_channel = grant.
  - in_meta_ready[grant] = out_meta_ready.
  - On the meta handshake, go to PKT.
  - out_pkt_valid = 0 in this state.
- State PKT:
  - out_pkt_valid = in_pkt_valid[grant]; in_pkt_ready[grant] = out_pkt_ready; out_pkt_channel = grant.
  - On a flit handshake with eop:
    - stat_pkt_cnt += 1.
    - rr_ptr <= (grant+1) mod NUM_CH, wrapping from NUM_CH-1 to 0.
    - Next state IDLE.
  - A single-flit packet (sop & eop) completes in one PKT cycle.
- Minimum cost per packet is 3 cycles: IDLE arbitration, META, one PKT flit.
- Error detection: stat_err_cnt += 1 on a PKT-state flit handshake with sop=1 that is not the first flit of the packet.
  - The flit is still forwarded unchanged.
  - Packet framing continues until eop.
- Counters wrap from 0xFFFFFFFF to 0 silently.
- Backpressure: with out_meta_ready or out_pkt_ready held low, the FSM holds state and grant indefinitely. Valid and data stay stable if the source holds them stable.
- A granted channel that drops in_pkt_valid mid-packet keeps its grant. out_pkt_valid = 0 until the channel resumes; there is no timeout.
- If the source deasserts in_meta_valid in META, out_meta_valid follows it low and the state holds. Metadata never transfers without a valid.
- Reset asserted mid-packet: all state clears immediately and asynchronously. The partial packet is truncated downstream, which is acceptable. Upstream sources must also be reset.
- A channel showing a non-sop head flit in IDLE is ineligible and is never granted. Upstream guarantees framing.

Test Plan:
- Single packet, NUM_CH=4, ch2 only, 3 flits, all ready=1:
  - meta out in cycle 2 with out_meta_channel=2.
  - flits out in cycles 3–5 with sop on the first and eop on the last; out_pkt_empty is passed through on eop.
  - stat_pkt_cnt=1.
- Fairness: all 4 channels continuously eligible, 1-flit packets, 12 packets total → grant order 0,1,2,3,0,1,2,3,…; each channel gets 3 packets; stat_pkt_cnt=12.
- Backpressure:
  - out_meta_ready=0 for 5 cycles → state held in META, in_meta_ready low, meta data stable.
  - Later out_pkt_ready toggling 1/0 on a 4-flit packet → exactly 4 flits out, in order, no duplicates.
- Wrap and skip: rr_ptr=3 with only ch1 eligible → ch1 granted; after its eop rr_ptr=2.
- Protocol error: sop asserted on flit 2 of 3 → flit forwarded unchanged, stat_err_cnt=1, packet ends on the eop flit, stat_pkt_cnt=1.
- Reset mid-packet: rst pulsed asynchronously during flit 2 of 4 → all valids/readies 0 within the reset pulse, counters 0, state IDLE; next packet from ch0 is granted normally.
